// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared state encoding, packet constants and byte-order helper
package uart_tx_scheduler_pkg;

  localparam int STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE         = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_STROBE       = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_START   = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_DONE    = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_RELEASE = 3'd4;
  localparam logic [STATE_WIDTH-1:0] ST_ACK          = 3'd5;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE         = ST_IDLE,
    STROBE       = ST_STROBE,
    WAIT_START   = ST_WAIT_START,
    WAIT_DONE    = ST_WAIT_DONE,
    WAIT_RELEASE = ST_WAIT_RELEASE,
    ACK          = ST_ACK
  } state_t;

  localparam int DEFAULT_NUM_REQ          = 4;
  localparam int DEFAULT_BYTES_PER_PACKET = 2;
  localparam int DEFAULT_ID_WIDTH         = 2;

  // Byte 0 is the most significant byte of a packet; the RX parser relies on the same order.
  localparam bit PACKET_MSB_FIRST = 1'b1;

  function automatic int byte_lsb(input int byte_index, input int bytes_per_packet);
    return PACKET_MSB_FIRST ? 8 * (bytes_per_packet - 1 - byte_index) : 8 * byte_index;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin winner select
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int ID_WIDTH = DEFAULT_ID_WIDTH
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] rr_pointer,
  output logic [NUM_REQ-1:0]  grant_onehot,
  output logic [ID_WIDTH-1:0] grant_index,
  output logic                grant_found
);

  int idx;

  // Scan upward from rr_pointer with wrap; the first set bit wins.
  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_found  = 1'b0;
    idx          = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_pointer) + off) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found       = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_index       = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin packet scheduler feeding a shared UART transmitter
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ          = DEFAULT_NUM_REQ,
  parameter int BYTES_PER_PACKET = DEFAULT_BYTES_PER_PACKET,
  parameter int ID_WIDTH         = DEFAULT_ID_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*8*BYTES_PER_PACKET-1:0] req_data,
  output logic [NUM_REQ-1:0]                  req_ack,
  output logic [ID_WIDTH-1:0]                 grant_id,
  output logic                                busy,
  output logic                                has_data,
  output logic [7:0]                          data_to_send,
  input  logic                                is_transmitting,
  input  logic                                transmission_done
);

  localparam int PACKET_WIDTH = 8 * BYTES_PER_PACKET;
  localparam int BIDX_WIDTH   = $clog2(BYTES_PER_PACKET) + 1;
  localparam logic [BIDX_WIDTH-1:0] LAST_BYTE = BIDX_WIDTH'(BYTES_PER_PACKET - 1);
  localparam logic [ID_WIDTH-1:0]   LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);

  state_t                  state, state_next;
  logic [ID_WIDTH-1:0]     rr_pointer, rr_pointer_next;
  logic [BIDX_WIDTH-1:0]   byte_index, byte_index_next;
  logic [PACKET_WIDTH-1:0] shadow, shadow_next, shadow_sel;
  logic [NUM_REQ-1:0]      req_ack_next;
  logic [ID_WIDTH-1:0]     grant_id_next;
  logic                    busy_next;
  logic                    has_data_next;
  logic [7:0]              data_next;

  logic [NUM_REQ-1:0]      win_onehot;
  logic [ID_WIDTH-1:0]     win_index;
  logic                    win_found;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req_valid    (req_valid),
    .rr_pointer   (rr_pointer),
    .grant_onehot (win_onehot),
    .grant_index  (win_index),
    .grant_found  (win_found)
  );

  always_comb begin
    shadow_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) shadow_sel = shadow_sel | req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

  always_comb begin
    state_next      = state;
    req_ack_next    = '0;
    grant_id_next   = grant_id;
    busy_next       = busy;
    has_data_next   = 1'b0;
    data_next       = data_to_send;
    byte_index_next = byte_index;
    rr_pointer_next = rr_pointer;
    shadow_next     = shadow;
    case (state)
      IDLE: begin
        // The transmitter may still be finishing a byte left over from an aborted packet.
        if (win_found && !is_transmitting && !transmission_done) begin
          shadow_next     = shadow_sel;
          grant_id_next   = win_index;
          busy_next       = 1'b1;
          byte_index_next = '0;
          rr_pointer_next = (win_index == LAST_REQ) ? '0 : win_index + 1'b1;
          data_next       = shadow_sel[byte_lsb(0, BYTES_PER_PACKET) +: 8];
          has_data_next   = 1'b1;
          state_next      = STROBE;
        end
      end
      STROBE: state_next = WAIT_START;
      WAIT_START: begin
        if (is_transmitting) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (transmission_done) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!transmission_done && !is_transmitting) begin
          if (byte_index < LAST_BYTE) begin
            byte_index_next = byte_index + 1'b1;
            data_next       = shadow[byte_lsb(int'(byte_index_next), BYTES_PER_PACKET) +: 8];
            has_data_next   = 1'b1;
            state_next      = STROBE;
          end else begin
            req_ack_next[grant_id] = 1'b1;
            state_next             = ACK;
          end
        end
      end
      ACK: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rr_pointer   <= '0;
      byte_index   <= '0;
      shadow       <= '0;
      req_ack      <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      has_data     <= 1'b0;
      data_to_send <= 8'h00;
    end else begin
      state        <= state_next;
      rr_pointer   <= rr_pointer_next;
      byte_index   <= byte_index_next;
      shadow       <= shadow_next;
      req_ack      <= req_ack_next;
      grant_id     <= grant_id_next;
      busy         <= busy_next;
      has_data     <= has_data_next;
      data_to_send <= data_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench with a behavioural UART transmitter at 4 clocks per bit
module tb_uart_tx_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int BPP      = 2;
  localparam int ID_WIDTH = 2;
  localparam int CPB      = 4;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*8*BPP-1:0]  req_data = {16'hC33C, 16'hBEEF, 16'h1234, 16'hA55A};
  logic [NUM_REQ-1:0]        req_ack;
  logic [ID_WIDTH-1:0]       grant_id;
  logic                      busy;
  logic                      has_data;
  logic [7:0]                data_to_send;
  logic                      is_tx_in;
  logic                      tx_done;

  logic       tx_busy = 1'b0;
  int         tx_cnt = 0;
  logic [9:0] tx_frame = '1;
  int         tx_done_cnt = 0;
  logic       force_tx = 1'b0;
  logic       tx_line;

  int         n_tests = 0;
  int         n_fail = 0;
  int         strobe_count = 0;
  int         order_err = 0;
  logic       prev_engaged = 1'b0;
  logic       busy_q = 1'b0;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_q[$];
  logic [ID_WIDTH-1:0] grant_log[$];

  always #5 clock = ~clock;

  assign tx_done  = (tx_done_cnt != 0);
  assign is_tx_in = tx_busy | force_tx;
  assign tx_line  = tx_busy ? tx_frame[tx_cnt/CPB] : 1'b1;

  uart_tx_scheduler #(
    .NUM_REQ          (NUM_REQ),
    .BYTES_PER_PACKET (BPP),
    .ID_WIDTH         (ID_WIDTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ack           (req_ack),
    .grant_id          (grant_id),
    .busy              (busy),
    .has_data          (has_data),
    .data_to_send      (data_to_send),
    .is_transmitting   (is_tx_in),
    .transmission_done (tx_done)
  );

  // Transmitter: start, 8 data bits LSB first, stop; then a 2-cycle done pulse. Not reset by the DUT reset.
  always @(posedge clock) begin
    if (tx_done_cnt != 0) tx_done_cnt <= tx_done_cnt - 1;
    if (tx_busy) begin
      if (tx_cnt == 10*CPB-1) begin
        tx_busy     <= 1'b0;
        tx_done_cnt <= 2;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end else if (has_data === 1'b1) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= 0;
      tx_frame <= {1'b1, data_to_send, 1'b0};
    end
  end

  always @(posedge clock) begin
    prev_engaged <= is_tx_in | tx_done;
    busy_q       <= busy;
    if (has_data === 1'b1) begin
      strobe_count <= strobe_count + 1;
      if (is_tx_in || tx_done || prev_engaged) order_err <= order_err + 1;
    end
    if (busy === 1'b1 && busy_q !== 1'b1) grant_log.push_back(grant_id);
    if (tx_busy && (tx_cnt % CPB) == CPB/2) begin
      if (tx_cnt/CPB >= 1 && tx_cnt/CPB <= 8) rx_byte[tx_cnt/CPB-1] <= tx_line;
      if (tx_cnt/CPB == 9) rx_q.push_back(rx_byte);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ack(output logic [NUM_REQ-1:0] ack);
    ack = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (req_ack != '0) begin
        ack = req_ack;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({req_ack, grant_id, busy, has_data, data_to_send} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got ack=%b id=%0d busy=%b hd=%b data=%h, expected all zero",
               req_ack, grant_id, busy, has_data, data_to_send);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int s0, r0;
    logic [NUM_REQ-1:0] ack;
    s0 = strobe_count;
    r0 = rx_q.size();
    @(negedge clock);
    req_valid = 4'b0001;
    @(negedge clock);
    n_tests++;
    if ({has_data, busy, grant_id, data_to_send} !== {1'b1, 1'b1, 2'd0, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_first_strobe: got hd=%b busy=%b id=%0d data=%h, expected 1 1 0 a5",
               has_data, busy, grant_id, data_to_send);
    end
    @(negedge clock);
    n_tests++;
    if (has_data !== 1'b0) begin
      n_fail++;
      $display("FAIL single_strobe_width: has_data=%b, expected 0", has_data);
    end
    wait_ack(ack);
    req_valid = '0;
    n_tests++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ack: got %b, expected 0001", ack);
    end
    n_tests++;
    if ({is_tx_in, tx_done, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL single_ack_line_idle: got tx=%b done=%b busy=%b, expected 0 0 1", is_tx_in, tx_done, busy);
    end
    @(negedge clock);
    n_tests++;
    if ({busy, req_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_after_ack: got busy=%b ack=%b, expected 0 0000", busy, req_ack);
    end
    n_tests++;
    if (rx_q.size() - r0 != 2 || rx_q[r0] !== 8'hA5 || rx_q[r0+1] !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_line_bytes: got %0d bytes, expected a5 5a", rx_q.size() - r0);
    end
    n_tests++;
    if (strobe_count - s0 != 2) begin
      n_fail++;
      $display("FAIL single_strobe_count: got %0d, expected 2", strobe_count - s0);
    end
  endtask

  task automatic test_contention();
    int s0, r0, g0;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] exp_ack [3];
    logic [7:0]         exp_rx [6];
    logic [ID_WIDTH-1:0] exp_g [3];
    exp_ack = '{4'b0001, 4'b0010, 4'b1000};
    exp_rx  = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hC3, 8'h3C};
    exp_g   = '{2'd0, 2'd1, 2'd3};
    do_reset();
    s0 = strobe_count;
    r0 = rx_q.size();
    g0 = grant_log.size();
    req_valid = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      wait_ack(ack);
      req_valid = req_valid & ~ack;
      n_tests++;
      if (ack !== exp_ack[k]) begin
        n_fail++;
        $display("FAIL contention_ack_%0d: got %b, expected %b", k, ack, exp_ack[k]);
      end
    end
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (grant_log.size() <= g0 + k || grant_log[g0+k] !== exp_g[k]) begin
        n_fail++;
        $display("FAIL contention_grant_id_%0d: got log size %0d, expected id %0d", k, grant_log.size() - g0, exp_g[k]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (rx_q.size() <= r0 + k || rx_q[r0+k] !== exp_rx[k]) begin
        n_fail++;
        $display("FAIL contention_line_byte_%0d: got %0d bytes, expected %h", k, rx_q.size() - r0, exp_rx[k]);
      end
    end
    n_tests++;
    if (strobe_count - s0 != 6) begin
      n_fail++;
      $display("FAIL contention_strobe_count: got %0d, expected 6", strobe_count - s0);
    end
  endtask

  task automatic test_fairness_wrap();
    logic [NUM_REQ-1:0] ack;
    @(negedge clock);
    req_valid = 4'b1001;
    wait_ack(ack);
    req_valid = req_valid & ~ack;
    n_tests++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL fairness_first: got %b, expected 0001", ack);
    end
    wait_ack(ack);
    req_valid = req_valid & ~ack;
    n_tests++;
    if (ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL fairness_second: got %b, expected 1000", ack);
    end
  endtask

  task automatic test_tx_busy_gate();
    int viol;
    logic [NUM_REQ-1:0] ack;
    do_reset();
    force_tx = 1'b1;
    req_valid = 4'b0100;
    viol = 0;
    repeat (12) begin
      @(negedge clock);
      if (has_data !== 1'b0 || busy !== 1'b0) viol++;
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL busy_gate_hold: got %0d granted cycles, expected 0", viol);
    end
    force_tx = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({has_data, grant_id} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL busy_gate_grant: got hd=%b id=%0d, expected 1 2", has_data, grant_id);
    end
    wait_ack(ack);
    req_valid = '0;
    n_tests++;
    if (ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL busy_gate_ack: got %b, expected 0100", ack);
    end
    // Pointer now sits at 3, so source 3 must precede source 0.
    @(negedge clock);
    req_valid = 4'b1001;
    wait_ack(ack);
    req_valid = req_valid & ~ack;
    n_tests++;
    if (ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_first: got %b, expected 1000", ack);
    end
    wait_ack(ack);
    req_valid = req_valid & ~ack;
    n_tests++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_second: got %b, expected 0001", ack);
    end
  endtask

  task automatic test_reset_mid_packet();
    int s0, r0, waited;
    logic [NUM_REQ-1:0] ack;
    logic [7:0] exp_rx [4];
    exp_rx = '{8'hA5, 8'h5A, 8'h12, 8'h34};
    do_reset();
    s0 = strobe_count;
    r0 = rx_q.size();
    req_valid = 4'b0001;
    waited = 0;
    while (strobe_count - s0 < 2 && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    repeat (8) @(negedge clock);
    n_tests++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_byte1_in_flight: tx_busy=%b after %0d cycles, expected 1", tx_busy, waited);
    end
    reset = 1'b1;
    req_valid = 4'b0010;
    @(negedge clock);
    n_tests++;
    if ({req_ack, grant_id, busy, has_data, data_to_send} !== '0) begin
      n_fail++;
      $display("FAIL midreset_values: got ack=%b id=%0d busy=%b hd=%b data=%h, expected all zero",
               req_ack, grant_id, busy, has_data, data_to_send);
    end
    reset = 1'b0;
    wait_ack(ack);
    req_valid = '0;
    n_tests++;
    if (ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL midreset_ack: got %b, expected 0010", ack);
    end
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (rx_q.size() <= r0 + k || rx_q[r0+k] !== exp_rx[k]) begin
        n_fail++;
        $display("FAIL midreset_line_byte_%0d: got %0d bytes, expected %h", k, rx_q.size() - r0, exp_rx[k]);
      end
    end
    n_tests++;
    if (order_err != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: got %0d strobes while transmitter engaged, expected 0", order_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness_wrap();
    test_tx_busy_gate();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
